control_unit: RTL and testbench

Hardwired control sequencer for the RISC CPU datapath. It steps through the fetch states T0–T2 and the per-opcode execute states, driving every register-enable, bus-select, select/encode (Gra/Grb/Grc) and memory strobe that the datapath takes as inputs. It sits directly upstream of `datapath` and replaces hand-sequenced control in benches. Its only datapath inputs are the instruction register contents and an external Stop request.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/ctrl_decode.sv | 25 ++
 rtl/control_unit.sv | 168 ++++++++++++++++
 tb/tb_control_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode constants, sequencer states and opcode classes for the RISC control unit.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        RESET_S = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
        T6      = 4'd7,
        T7      = 4'd8,
        HALT    = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_ALU_R,
        C_ALU_I,
        C_LD,
        C_ST,
        C_IO_IN,
        C_IO_OUT,
        C_MFHI,
        C_MFLO,
        C_NOP,
        C_HALT
    } op_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; undefined opcodes fall into the NOP class.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = C_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = C_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:      op_class = C_ALU_I;
            OP_LD:                         op_class = C_LD;
            OP_ST:                         op_class = C_ST;
            OP_IN:                         op_class = C_IO_IN;
            OP_OUT:                        op_class = C_IO_OUT;
            OP_MFHI:                       op_class = C_MFHI;
            OP_MFLO:                       op_class = C_MFLO;
            OP_HALT:                       op_class = C_HALT;
            default:                       op_class = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, per-class execute T3-T7, HALT until Reset.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        BAout,
    output logic        InPortout,
    output logic        Cout,
    output logic        PCin,
    output logic        Zin,
    output logic        MDRin,
    output logic        MARin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        IRin,
    output logic        OutPortin,
    output logic        CONin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write
);

    state_t    state;
    state_t    next_state;
    state_t    end_state;
    op_class_t op_class;
    logic      ir_unused;

    assign ir_unused = ^IR[26:0];

    ctrl_decode u_decode (
        .opcode   (IR[31:27]),
        .op_class (op_class)
    );

    assign Zhighout = 1'b0;
    assign HIin     = 1'b0;
    assign LOin     = 1'b0;
    assign CONin    = 1'b0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= RESET_S;
        else
            state <= next_state;
    end

    // Stop only matters in an instruction's final state.
    assign end_state = Stop ? HALT : T0;

    always_comb begin
        next_state = state;
        case (state)
            RESET_S: next_state = T0;
            T0:      next_state = T1;
            T1:      next_state = T2;
            T2:      next_state = (op_class == C_NOP) ? end_state : T3;
            T3: begin
                case (op_class)
                    C_HALT:                                     next_state = HALT;
                    C_IO_IN, C_IO_OUT, C_MFHI, C_MFLO, C_NOP:   next_state = end_state;
                    default:                                    next_state = T4;
                endcase
            end
            T4:      next_state = T5;
            T5:      next_state = (op_class == C_LD || op_class == C_ST) ? T6 : end_state;
            T6:      next_state = T7;
            T7:      next_state = end_state;
            HALT:    next_state = HALT;
            default: next_state = RESET_S;
        endcase
    end

    always_comb begin
        Run       = (state != RESET_S) && (state != HALT);
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        BAout     = 1'b0;
        InPortout = 1'b0;
        Cout      = 1'b0;
        PCin      = 1'b0;
        Zin       = 1'b0;
        MDRin     = 1'b0;
        MARin     = 1'b0;
        Yin       = 1'b0;
        IRin      = 1'b0;
        OutPortin = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        case (state)
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            T3: begin
                case (op_class)
                    C_ALU_R, C_ALU_I: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_LD, C_ST:       begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_IO_IN:          begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_IO_OUT:         begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    C_MFHI:           begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_MFLO:           begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                case (op_class)
                    C_ALU_R:                begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                    C_ALU_I, C_LD, C_ST:    begin Cout = 1'b1; Zin = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                case (op_class)
                    C_ALU_R, C_ALU_I: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_LD, C_ST:       begin Zlowout = 1'b1; MARin = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                case (op_class)
                    C_LD:    begin Read = 1'b1; MDRin = 1'b1; end
                    C_ST:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    default: ;
                endcase
            end
            T7: begin
                case (op_class)
                    C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST:    Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle output vectors against an instruction-level model.
module tb_control_unit;

    logic        Clock, Reset, Stop;
    logic [31:0] IR;
    logic Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout;
    logic PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write;

    int errors = 0;
    int checks = 0;

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop), .Run(Run),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .BAout(BAout), .InPortout(InPortout), .Cout(Cout),
        .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .IRin(IRin), .OutPortin(OutPortin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .IncPC(IncPC), .Read(Read), .Write(Write)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [27:0] obs;
    assign obs = {Run, PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout,
                  PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin, CONin,
                  Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write};

    localparam logic [27:0] M_RUN = 28'd1 << 27, M_PCOUT = 28'd1 << 26, M_ZLOWOUT = 28'd1 << 24;
    localparam logic [27:0] M_MDROUT = 28'd1 << 23, M_HIOUT = 28'd1 << 22, M_LOOUT = 28'd1 << 21;
    localparam logic [27:0] M_BAOUT = 28'd1 << 20, M_INPORTOUT = 28'd1 << 19, M_COUT = 28'd1 << 18;
    localparam logic [27:0] M_PCIN = 28'd1 << 17, M_ZIN = 28'd1 << 16, M_MDRIN = 28'd1 << 15;
    localparam logic [27:0] M_MARIN = 28'd1 << 14, M_YIN = 28'd1 << 13, M_IRIN = 28'd1 << 10;
    localparam logic [27:0] M_OUTPORTIN = 28'd1 << 9, M_GRA = 28'd1 << 7, M_GRB = 28'd1 << 6;
    localparam logic [27:0] M_GRC = 28'd1 << 5, M_RIN = 28'd1 << 4, M_ROUT = 28'd1 << 3;
    localparam logic [27:0] M_INCPC = 28'd1 << 2, M_READ = 28'd1 << 1, M_WRITE = 28'd1;

    // Instruction kinds: 0 reg-reg, 1 imm, 2 ld, 3 st, 4 in, 5 out, 6 mfhi, 7 mflo, 8 nop, 9 halt
    function automatic int kind_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return 0;
            5'b01100, 5'b01101, 5'b01110:           return 1;
            5'b00000: return 2;
            5'b00010: return 3;
            5'b10110: return 4;
            5'b10111: return 5;
            5'b11000: return 6;
            5'b11001: return 7;
            5'b11011: return 9;
            default:  return 8;
        endcase
    endfunction

    function automatic int len_of(input logic [4:0] op);
        int lens[10] = '{6, 6, 8, 8, 4, 4, 4, 4, 3, 4};
        return lens[kind_of(op)];
    endfunction

    function automatic logic [27:0] exp_vec(input logic [4:0] op, input int k);
        int kd = kind_of(op);
        logic [27:0] v = M_RUN;
        if (k == 0)      v |= M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
        else if (k == 1) v |= M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
        else if (k == 2) v |= M_MDROUT | M_IRIN;
        else if (kd <= 1) begin
            if (k == 3) v |= M_GRB | M_ROUT | M_YIN;
            if (k == 4) v |= (kd == 0) ? (M_GRC | M_ROUT | M_ZIN) : (M_COUT | M_ZIN);
            if (k == 5) v |= M_ZLOWOUT | M_GRA | M_RIN;
        end else if (kd == 2 || kd == 3) begin
            if (k == 3) v |= M_GRB | M_BAOUT | M_YIN;
            if (k == 4) v |= M_COUT | M_ZIN;
            if (k == 5) v |= M_ZLOWOUT | M_MARIN;
            if (k == 6) v |= (kd == 2) ? (M_READ | M_MDRIN) : (M_GRA | M_ROUT | M_MDRIN);
            if (k == 7) v |= (kd == 2) ? (M_MDROUT | M_GRA | M_RIN) : M_WRITE;
        end else if (k == 3) begin
            case (kd)
                4: v |= M_INPORTOUT | M_GRA | M_RIN;
                5: v |= M_GRA | M_ROUT | M_OUTPORTIN;
                6: v |= M_HIOUT | M_GRA | M_RIN;
                7: v |= M_LOOUT | M_GRA | M_RIN;
                default: ;
            endcase
        end
        return v;
    endfunction

    // At most one bus driver per cycle, checked on every falling edge.
    always @(negedge Clock) begin
        checks++;
        if ($countones({PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout, Rout}) > 1) begin
            errors++;
            $display("FAIL bus_drivers t=%0t: got %0d drivers, required <=1", $time,
                     $countones({PCout, Zhighout, Zlowout, MDRout, HIout, LOout, BAout, InPortout, Cout, Rout}));
        end
    end

    task automatic apply_reset();
        Reset = 1'b1;
        Stop  = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    function automatic logic [31:0] make_ir(input logic [4:0] op);
        logic [31:0] r = $urandom();
        return {op, r[26:0]};
    endfunction

    task automatic test_reset();
        Reset = 1'b1; Stop = 1'b0; IR = 32'h0;
        @(negedge Clock);
        checks++;
        if (obs !== 28'h0) begin errors++; $display("FAIL reset_hold: got %h required %h", obs, 28'h0); end
        Reset = 1'b0;
        #1;
        checks++;
        if (obs !== 28'h0) begin errors++; $display("FAIL reset_s_after_release: got %h required %h", obs, 28'h0); end
        @(negedge Clock);
        checks++;
        if (obs !== exp_vec(5'b11010, 0)) begin errors++; $display("FAIL reset_to_t0: got %h required %h", obs, exp_vec(5'b11010, 0)); end
    endtask

    task automatic test_addi();
        logic [4:0] op = 5'b01100;
        IR = 32'h611FFFFD;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs !== exp_vec(op, k)) begin errors++; $display("FAIL addi_step%0d: got %h required %h", k, obs, exp_vec(op, k)); end
            @(posedge Clock); @(negedge Clock);
        end
        checks++;
        if (obs !== exp_vec(op, 0)) begin errors++; $display("FAIL addi_back_to_t0: got %h required %h", obs, exp_vec(op, 0)); end
    endtask

    task automatic test_add();
        logic [4:0] op = 5'b00011;
        IR = 32'h18000000;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs !== exp_vec(op, k)) begin errors++; $display("FAIL add_step%0d: got %h required %h", k, obs, exp_vec(op, k)); end
            @(posedge Clock); @(negedge Clock);
        end
    endtask

    task automatic test_ld();
        logic [4:0] op = 5'b00000;
        int reads = 0;
        IR = 32'h00000000;
        for (int k = 0; k < 8; k++) begin
            reads += int'(Read);
            checks++;
            if (obs !== exp_vec(op, k)) begin errors++; $display("FAIL ld_step%0d: got %h required %h", k, obs, exp_vec(op, k)); end
            @(posedge Clock); @(negedge Clock);
        end
        checks++;
        if (reads != 2) begin errors++; $display("FAIL ld_read_cycles: got %0d required 2", reads); end
        checks++;
        if (obs !== exp_vec(op, 0)) begin errors++; $display("FAIL ld_length: got %h required %h", obs, exp_vec(op, 0)); end
    endtask

    task automatic test_st();
        logic [4:0] op = 5'b00010;
        int writes = 0;
        IR = 32'h10000000;
        for (int k = 0; k < 8; k++) begin
            writes += int'(Write);
            checks++;
            if (obs !== exp_vec(op, k)) begin errors++; $display("FAIL st_step%0d: got %h required %h", k, obs, exp_vec(op, k)); end
            @(posedge Clock); @(negedge Clock);
        end
        checks++;
        if (writes != 1) begin errors++; $display("FAIL st_write_cycles: got %0d required 1", writes); end
    endtask

    task automatic test_random_stream();
        for (int n = 0; n < 40; n++) begin
            logic [4:0] op;
            logic [31:0] r = $urandom();
            op = r[4:0];
            if (op == 5'b11011) op = 5'b11010;
            IR = make_ir(op);
            for (int k = 0; k < len_of(op); k++) begin
                // Stop raised before the last state must be ignored.
                Stop = (k == len_of(op) - 1) ? 1'b0 : r[8 + (k % 8)];
                checks++;
                if (obs !== exp_vec(op, k)) begin
                    errors++;
                    $display("FAIL rand_op%b_step%0d: got %h required %h", op, k, obs, exp_vec(op, k));
                end
                @(posedge Clock); @(negedge Clock);
            end
            Stop = 1'b0;
        end
    endtask

    task automatic test_stop_and_halt();
        logic [4:0] op = 5'b00011;
        int bad = 0;
        apply_reset();
        IR = make_ir(op);
        for (int k = 0; k < 6; k++) begin
            Stop = (k == 5);
            checks++;
            if (obs !== exp_vec(op, k)) begin errors++; $display("FAIL stop_add_step%0d: got %h required %h", k, obs, exp_vec(op, k)); end
            @(posedge Clock); @(negedge Clock);
        end
        Stop = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (obs !== 28'h0) bad++;
            @(negedge Clock);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stop_halted: got %0d nonzero cycles required 0", bad); end

        apply_reset();
        op = 5'b11011;
        IR = 32'hD8000000;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs !== exp_vec(op, k)) begin errors++; $display("FAIL halt_step%0d: got %h required %h", k, obs, exp_vec(op, k)); end
            @(posedge Clock); @(negedge Clock);
        end
        bad = 0;
        IR = 32'h18000000;
        for (int c = 0; c < 20; c++) begin
            if (obs !== 28'h0) bad++;
            @(negedge Clock);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL halt_held: got %0d nonzero cycles required 0", bad); end
    endtask

    task automatic test_async_reset();
        logic [4:0] op = 5'b00010;
        apply_reset();
        IR = 32'h10000000;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clock); @(negedge Clock);
        end
        checks++;
        if (obs !== exp_vec(op, 6)) begin errors++; $display("FAIL areset_in_t6: got %h required %h", obs, exp_vec(op, 6)); end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if (obs !== 28'h0) begin errors++; $display("FAIL areset_immediate: got %h required %h", obs, 28'h0); end
        @(negedge Clock);
        checks++;
        if (Write !== 1'b0) begin errors++; $display("FAIL areset_no_write: got %b required 0", Write); end
        Reset = 1'b0;
        #1;
        checks++;
        if (obs !== 28'h0) begin errors++; $display("FAIL areset_reset_s: got %h required %h", obs, 28'h0); end
        @(negedge Clock);
        checks++;
        if (obs !== exp_vec(op, 0)) begin errors++; $display("FAIL areset_to_t0: got %h required %h", obs, exp_vec(op, 0)); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add();
        test_ld();
        test_st();
        test_random_stream();
        test_stop_and_halt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
